// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Adds a valid bit, hold, flush, and load-use hazard
// detection that inserts a bubble and counts the bubbles it inserts.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               idValid,
  input  logic [DATA_W-1:0]  pcAdded,
  input  logic [DATA_W-1:0]  read1,
  input  logic [DATA_W-1:0]  read2,
  input  logic [DATA_W-1:0]  i16_0Extended,
  input  logic [RA_W-1:0]    rs,
  input  logic [RA_W-1:0]    rt,
  input  logic [RA_W-1:0]    rd,
  input  logic               regDst,
  input  logic               aluSrc,
  input  logic               branch,
  input  logic               memWrite,
  input  logic               memRead,
  input  logic               regWrite,
  input  logic               memToReg,
  input  logic [ALUOP_W-1:0] aluOp,
  input  logic               flush,
  input  logic               exStall,
  output logic               outValid,
  output logic [DATA_W-1:0]  outpcAdded,
  output logic [DATA_W-1:0]  outRead1,
  output logic [DATA_W-1:0]  outRead2,
  output logic [DATA_W-1:0]  outi16_0Extended,
  output logic [RA_W-1:0]    outRs,
  output logic [RA_W-1:0]    outRt,
  output logic [RA_W-1:0]    outRd,
  output logic               outRegDst,
  output logic               outAluSrc,
  output logic               outBranch,
  output logic               outMemWrite,
  output logic               outMemRead,
  output logic               outRegWrite,
  output logic               outMemToReg,
  output logic [ALUOP_W-1:0] outAluOp,
  output logic               holdUpstream,
  output logic [CNT_W-1:0]   stallCount
);

  logic [RA_W-1:0] ex_dest;
  logic            hazard;
  logic            bubble;

  // A load in EX whose destination (never r0) feeds the instruction in ID.
  always_comb begin
    ex_dest      = outRegDst ? outRd : outRt;
    hazard       = idValid & outValid & outMemRead &
                   (ex_dest != {RA_W{1'b0}}) &
                   ((ex_dest == rs) | (ex_dest == rt));
    holdUpstream = exStall | (hazard & ~flush);
    bubble       = rst | flush | (~exStall & hazard);
  end

  // Pipeline contents: clear on reset/bubble, hold on exStall, else load.
  always_ff @(posedge clk) begin
    if (bubble) begin
      outValid         <= 1'b0;
      outpcAdded       <= {DATA_W{1'b0}};
      outRead1         <= {DATA_W{1'b0}};
      outRead2         <= {DATA_W{1'b0}};
      outi16_0Extended <= {DATA_W{1'b0}};
      outRs            <= {RA_W{1'b0}};
      outRt            <= {RA_W{1'b0}};
      outRd            <= {RA_W{1'b0}};
      outRegDst        <= 1'b0;
      outAluSrc        <= 1'b0;
      outBranch        <= 1'b0;
      outMemWrite      <= 1'b0;
      outMemRead       <= 1'b0;
      outRegWrite      <= 1'b0;
      outMemToReg      <= 1'b0;
      outAluOp         <= {ALUOP_W{1'b0}};
    end else if (!exStall) begin
      outValid         <= idValid;
      outpcAdded       <= pcAdded;
      outRead1         <= read1;
      outRead2         <= read2;
      outi16_0Extended <= i16_0Extended;
      outRs            <= rs;
      outRt            <= rt;
      outRd            <= rd;
      outRegDst        <= regDst;
      outAluSrc        <= aluSrc;
      outBranch        <= branch;
      outMemWrite      <= memWrite;
      outMemRead       <= memRead;
      outRegWrite      <= regWrite;
      outMemToReg      <= memToReg;
      outAluOp         <= aluOp;
    end else begin
      outValid         <= outValid;
      outpcAdded       <= outpcAdded;
      outRead1         <= outRead1;
      outRead2         <= outRead2;
      outi16_0Extended <= outi16_0Extended;
      outRs            <= outRs;
      outRt            <= outRt;
      outRd            <= outRd;
      outRegDst        <= outRegDst;
      outAluSrc        <= outAluSrc;
      outBranch        <= outBranch;
      outMemWrite      <= outMemWrite;
      outMemRead       <= outMemRead;
      outRegWrite      <= outRegWrite;
      outMemToReg      <= outMemToReg;
      outAluOp         <= outAluOp;
    end
  end

  // Load-use bubble counter; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= {CNT_W{1'b0}};
    end else if (!flush && !exStall && hazard && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + CNT_W'(1);
    end else begin
      stallCount <= stallCount;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scenario testbench for id_ex_stage_reg (CNT_W=2 so saturation is reachable).
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RW = 5;
  localparam int CW = 2;

  typedef logic [153:0] pat_t;          // {valid,pc,r1,r2,imm,rs,rt,rd,ctrl7,aluop}
  typedef logic [CW+153:0] exp_t;       // {stallCount, pat_t}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, idValid, flush, exStall;
  logic [DW-1:0] pcAdded, read1, read2, i16_0Extended;
  logic [RW-1:0] rs, rt, rd;
  logic [6:0] ctrl;
  logic regDst, aluSrc, branch, memWrite, memRead, regWrite, memToReg;
  logic [AW-1:0] aluOp;
  assign {regDst, aluSrc, branch, memWrite, memRead, regWrite, memToReg} = ctrl;

  logic outValid, outRegDst, outAluSrc, outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg;
  logic [DW-1:0] outpcAdded, outRead1, outRead2, outi16_0Extended;
  logic [RW-1:0] outRs, outRt, outRd;
  logic [AW-1:0] outAluOp;
  logic holdUpstream;
  logic [CW-1:0] stallCount;

  id_ex_stage_reg #(.DATA_W(DW), .ALUOP_W(AW), .RA_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .idValid(idValid), .pcAdded(pcAdded), .read1(read1), .read2(read2),
    .i16_0Extended(i16_0Extended), .rs(rs), .rt(rt), .rd(rd), .regDst(regDst), .aluSrc(aluSrc),
    .branch(branch), .memWrite(memWrite), .memRead(memRead), .regWrite(regWrite),
    .memToReg(memToReg), .aluOp(aluOp), .flush(flush), .exStall(exStall), .outValid(outValid),
    .outpcAdded(outpcAdded), .outRead1(outRead1), .outRead2(outRead2),
    .outi16_0Extended(outi16_0Extended), .outRs(outRs), .outRt(outRt), .outRd(outRd),
    .outRegDst(outRegDst), .outAluSrc(outAluSrc), .outBranch(outBranch),
    .outMemWrite(outMemWrite), .outMemRead(outMemRead), .outRegWrite(outRegWrite),
    .outMemToReg(outMemToReg), .outAluOp(outAluOp), .holdUpstream(holdUpstream),
    .stallCount(stallCount)
  );

  exp_t exp_q[$];
  logic [CW-1:0] exp_cnt;
  int tests_run = 0;
  int tests_failed = 0;
  exp_t e;

  // Shared instructions: lw r8 <- [r2]; a consumer reading r8; an ALU op.
  pat_t lw_p, cons_p, alu_p;

  function automatic pat_t mk(input logic v, input logic [31:0] pc, r1, r2, imm,
                              input logic [4:0] s, t, d, input logic [6:0] c, input logic [2:0] op);
    return {v, pc, r1, r2, imm, s, t, d, c, op};
  endfunction

  function automatic exp_t observed();
    return {stallCount, outValid, outpcAdded, outRead1, outRead2, outi16_0Extended, outRs, outRt,
            outRd, outRegDst, outAluSrc, outBranch, outMemWrite, outMemRead, outRegWrite,
            outMemToReg, outAluOp};
  endfunction

  task automatic drive(input pat_t p);
    {idValid, pcAdded, read1, read2, i16_0Extended, rs, rt, rd, ctrl, aluOp} = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; exStall = 1'b0;
    drive(mk(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_FFFF,
             5'd8, 5'd8, 5'd8, 7'h7F, 3'd7));
    exp_cnt = 2'd0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({exp_cnt, 154'd0});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got %h want %h", i, observed(), e);
      end
      tests_run++;
      if (holdUpstream !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: got %b want 0", i, holdUpstream);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    pat_t pats [3];
    pats[0] = mk(1'b1, 32'h0000_0010, 32'h5, 32'h7, 32'h0000_1234, 5'd1, 5'd2, 5'd3, 7'b0000010, 3'b010);
    pats[1] = mk(1'b0, 32'hDEAD_BEEF, 32'hCAFE_0001, 32'h0BAD_F00D, 32'hFFFF_FFF0, 5'd31, 5'd30, 5'd29, 7'b1111011, 3'b101);
    pats[2] = mk(1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd16, 5'd15, 5'd14, 7'b1010001, 3'b111);
    for (int i = 0; i < 3; i++) begin
      drive(pats[i]);
      tests_run++;
      if (holdUpstream !== 1'b0) begin
        tests_failed++;
        $display("FAIL pass_hold[%0d]: got %b want 0", i, holdUpstream);
      end
      exp_q.push_back({exp_cnt, pats[i]});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL pass_data[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_load_use();
    pat_t lw_rd, cons_rd;
    // Two variants: destination in rt (regDst=0) and in rd (regDst=1, consumer uses rt).
    lw_rd   = mk(1'b1, 32'h30, 32'h300, 32'h0, 32'hC, 5'd3, 5'd0, 5'd12, 7'b1000111, 3'd0);
    cons_rd = mk(1'b1, 32'h34, 32'h33, 32'h44, 32'h0, 5'd4, 5'd12, 5'd5, 7'b1000010, 3'b110);
    for (int v = 0; v < 2; v++) begin
      drive(v == 0 ? lw_p : lw_rd);
      exp_q.push_back({exp_cnt, (v == 0 ? lw_p : lw_rd)});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL lu_load[%0d]: got %h want %h", v, observed(), e);
      end
      drive(v == 0 ? cons_p : cons_rd);
      tests_run++;
      if (holdUpstream !== 1'b1) begin
        tests_failed++;
        $display("FAIL lu_hold[%0d]: got %b want 1", v, holdUpstream);
      end
      exp_cnt = sat_inc(exp_cnt);
      exp_q.push_back({exp_cnt, 154'd0});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL lu_bubble[%0d]: got %h want %h", v, observed(), e);
      end
      tests_run++;
      if (holdUpstream !== 1'b0) begin
        tests_failed++;
        $display("FAIL lu_release[%0d]: got %b want 0", v, holdUpstream);
      end
      exp_q.push_back({exp_cnt, (v == 0 ? cons_p : cons_rd)});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL lu_consumer[%0d]: got %h want %h", v, observed(), e);
      end
    end
  endtask

  task automatic test_zero_reg();
    pat_t pats [4];
    // lw to r0 then consumer of r0; lw to r8 then an idValid=0 consumer of r8.
    pats[0] = mk(1'b1, 32'h50, 32'h500, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 7'b0000111, 3'd0);
    pats[1] = mk(1'b1, 32'h54, 32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd9, 7'b1000010, 3'b010);
    pats[2] = lw_p;
    pats[3] = mk(1'b0, 32'h5C, 32'h3, 32'h4, 32'h0, 5'd8, 5'd8, 5'd9, 7'b1000010, 3'b010);
    for (int i = 0; i < 4; i++) begin
      drive(pats[i]);
      tests_run++;
      if (holdUpstream !== 1'b0) begin
        tests_failed++;
        $display("FAIL zero_hold[%0d]: got %b want 0", i, holdUpstream);
      end
      exp_q.push_back({exp_cnt, pats[i]});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL zero_data[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_stall_flush();
    drive(alu_p);
    exp_q.push_back({exp_cnt, alu_p});
    tick();
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e) begin
      tests_failed++;
      $display("FAIL sf_load: got %h want %h", observed(), e);
    end
    exStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 3);
      drive(cons_p);
      tests_run++;
      if (holdUpstream !== 1'b1) begin
        tests_failed++;
        $display("FAIL sf_hold[%0d]: got %b want 1", i, holdUpstream);
      end
      exp_q.push_back({exp_cnt, (i == 3 ? 154'd0 : alu_p)});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL sf_state[%0d]: got %h want %h", i, observed(), e);
      end
    end
    flush = 1'b0; exStall = 1'b0;
    // exStall while a hazard is pending: the load is held and nothing is counted.
    drive(lw_p);
    tick();
    for (int i = 0; i < 4; i++) begin
      exStall = (i < 2);
      drive(cons_p);
      tests_run++;
      if (holdUpstream !== (i < 3)) begin
        tests_failed++;
        $display("FAIL sh_hold[%0d]: got %b want %b", i, holdUpstream, (i < 3));
      end
      if (i == 2) exp_cnt = sat_inc(exp_cnt);
      exp_q.push_back({exp_cnt, (i < 2 ? lw_p : (i == 2 ? 154'd0 : cons_p))});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL sh_state[%0d]: got %h want %h", i, observed(), e);
      end
    end
    // Flush while a hazard is pending: bubble, no hold, no count.
    drive(lw_p);
    tick();
    flush = 1'b1;
    drive(cons_p);
    tests_run++;
    if (holdUpstream !== 1'b0) begin
      tests_failed++;
      $display("FAIL fh_hold: got %b want 0", holdUpstream);
    end
    exp_q.push_back({exp_cnt, 154'd0});
    tick();
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e) begin
      tests_failed++;
      $display("FAIL fh_state: got %h want %h", observed(), e);
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(alu_p);
    tick();
    exStall = 1'b1;
    rst = 1'b1;
    drive(cons_p);
    exp_cnt = 2'd0;
    exp_q.push_back({exp_cnt, 154'd0});
    tick();
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e) begin
      tests_failed++;
      $display("FAIL rst_mid_stall: got %h want %h", observed(), e);
    end
    rst = 1'b0; exStall = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(lw_p);
      exp_q.push_back({exp_cnt, lw_p});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL sat_load[%0d]: got %h want %h", i, observed(), e);
      end
      drive(cons_p);
      exp_cnt = sat_inc(exp_cnt);
      exp_q.push_back({exp_cnt, 154'd0});
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL sat_bubble[%0d]: got %h want %h", i, observed(), e);
      end
    end
    tests_run++;
    if (stallCount !== 2'd3) begin
      tests_failed++;
      $display("FAIL sat_final: got %0d want 3", stallCount);
    end
  endtask

  initial begin
    lw_p   = mk(1'b1, 32'h20, 32'h100, 32'h0, 32'h4, 5'd2, 5'd8, 5'd0, 7'b0000111, 3'd0);
    cons_p = mk(1'b1, 32'h24, 32'h11, 32'h22, 32'h0, 5'd8, 5'd9, 5'd10, 7'b1000010, 3'b010);
    alu_p  = mk(1'b1, 32'h40, 32'hAA, 32'hBB, 32'h8, 5'd1, 5'd2, 5'd3, 7'b0100010, 3'b001);
    rst = 1'b1; flush = 1'b0; exStall = 1'b0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_reg();
    test_stall_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
